// File: rtl/gearbox_pkg.sv
// Shared constants and helpers for the parametrised TX/RX gearboxes.
package gearbox_pkg;
    localparam int GB_IL_BLOCK_W = 67;
    localparam int GB_XCVR_W     = 20;
    localparam int STARVE_CNT_W  = 16;

    // Wide enough for fill + IN_W without overflow.
    function automatic int gb_fill_w(input int in_w, input int out_w);
        return $clog2(in_w + out_w);
    endfunction
endpackage

// File: rtl/gearbox_merge_shift.sv
// Merges the MSB-aligned residue with an optional new word and splits off the
// next OUT_W-bit slice plus the leftover residue (zero-padded below fill).
module gearbox_merge_shift
    import gearbox_pkg::*;
#(
    parameter int IN_W  = GB_IL_BLOCK_W,
    parameter int OUT_W = GB_XCVR_W,
    parameter int FW    = gb_fill_w(GB_IL_BLOCK_W, GB_XCVR_W)
) (
    input  logic [IN_W-2:0]  res,
    input  logic [FW-1:0]    fill,
    input  logic [IN_W-1:0]  din,
    input  logic             din_en,
    output logic [OUT_W-1:0] slice,
    output logic [IN_W-2:0]  res_nxt
);
    // Longest merged stream is (OUT_W-1) residue bits + IN_W new bits.
    localparam int WW = IN_W + OUT_W - 1;

    logic [WW-1:0] res_al;
    logic [WW-1:0] din_al;
    logic [WW-1:0] wide;

    always_comb begin
        res_al = '0;
        res_al[WW-1 -: IN_W-1] = res;
        din_al = '0;
        din_al[WW-1 -: IN_W] = din_en ? din : '0;
        wide    = res_al | (din_al >> fill);
        slice   = wide[WW-1 -: OUT_W];
        res_nxt = wide[IN_W-2:0];
    end
endmodule

// File: rtl/gearbox_tx_param.sv
// IN_W -> OUT_W transmit gearbox with self-generated din_ready schedule.
// Optional starvation counter enabled by defining GEARBOX_STATS_EN.
module gearbox_tx_param
    import gearbox_pkg::*;
#(
    parameter int IN_W  = GB_IL_BLOCK_W,
    parameter int OUT_W = GB_XCVR_W
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [IN_W-1:0]         din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [OUT_W-1:0]        dout,
    output logic                    dout_valid,
    output logic [STARVE_CNT_W-1:0] starve_cnt
);
    localparam int FW = gb_fill_w(IN_W, OUT_W);
    localparam logic [FW-1:0] OUT_F  = FW'(OUT_W);
    localparam logic [FW-1:0] GROW_F = FW'(IN_W - OUT_W);

    if (IN_W < OUT_W) begin : g_chk_in_w
        $error("gearbox_tx_param: IN_W must be >= OUT_W");
    end
    if (OUT_W < 1) begin : g_chk_out_w
        $error("gearbox_tx_param: OUT_W must be >= 1");
    end

    logic [IN_W-2:0]  res, res_nxt;
    logic [FW-1:0]    fill;
    logic [OUT_W-1:0] slice;
    logic             room, accept;

    assign room      = fill < OUT_F;
    assign din_ready = !arst && room;
    assign accept    = room && din_valid;

    gearbox_merge_shift #(.IN_W(IN_W), .OUT_W(OUT_W), .FW(FW)) u_merge (
        .res     (res),
        .fill    (fill),
        .din     (din),
        .din_en  (accept),
        .slice   (slice),
        .res_nxt (res_nxt)
    );

    always_ff @(posedge clk) begin
        if (arst) begin
            res        <= '0;
            fill       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (!room) begin
            res        <= res_nxt;
            fill       <= fill - OUT_F;
            dout       <= slice;
            dout_valid <= 1'b1;
        end else if (din_valid) begin
            res        <= res_nxt;
            fill       <= fill + GROW_F;
            dout       <= slice;
            dout_valid <= 1'b1;
        end else begin
            // Starved: hold residue and dout, flag the gap.
            dout_valid <= 1'b0;
        end
    end

`ifdef GEARBOX_STATS_EN
    logic [STARVE_CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (arst)
            cnt <= '0;
        else if (din_ready && !din_valid && cnt != '1)
            cnt <= cnt + 1'b1;
    end
    assign starve_cnt = cnt;
`else
    assign starve_cnt = '0;
`endif
endmodule

// File: tb/tb_gearbox_tx_param.sv
// Directed bench for gearbox_tx_param: 67/20, 32/32 and 66/32 instances.
module tb_gearbox_tx_param;
    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic [66:0] din0;  logic v0, r0; logic [19:0] dout0; logic dv0; logic [15:0] sc0;
    logic [31:0] din1;  logic v1, r1; logic [31:0] dout1; logic dv1; logic [15:0] sc1;
    logic [65:0] din2;  logic v2, r2; logic [31:0] dout2; logic dv2; logic [15:0] sc2;

    gearbox_tx_param #(.IN_W(67), .OUT_W(20)) d0 (.clk(clk), .arst(arst), .din(din0),
        .din_valid(v0), .din_ready(r0), .dout(dout0), .dout_valid(dv0), .starve_cnt(sc0));
    gearbox_tx_param #(.IN_W(32), .OUT_W(32)) d1 (.clk(clk), .arst(arst), .din(din1),
        .din_valid(v1), .din_ready(r1), .dout(dout1), .dout_valid(dv1), .starve_cnt(sc1));
    gearbox_tx_param #(.IN_W(66), .OUT_W(32)) d2 (.clk(clk), .arst(arst), .din(din2),
        .din_valid(v2), .din_ready(r2), .dout(dout2), .dout_valid(dv2), .starve_cnt(sc2));

    int errs = 0;
    int checks = 0;

    // Serial bit-queue reference models (first-transmitted bit at the front).
    logic q0[$];
    logic q2[$];
    logic [19:0] e0;
    logic [31:0] e2;
    int widx = 0;

    function automatic logic [66:0] w67(input int unsigned k);
        return {3'(k), k * 32'h9E37_79B9, ~k};
    endfunction

    task automatic m0_edge(input logic rdy, input logic v, input logic [66:0] d, output logic ev);
        if (rdy && v) for (int i = 66; i >= 0; i--) q0.push_back(d[i]);
        ev = 1'b0;
        if (!rdy || v) begin
            for (int i = 19; i >= 0; i--) e0[i] = q0.pop_front();
            ev = 1'b1;
        end
    endtask

    task automatic m2_edge(input logic rdy, input logic v, input logic [65:0] d, output logic ev);
        if (rdy && v) for (int i = 65; i >= 0; i--) q2.push_back(d[i]);
        ev = 1'b0;
        if (!rdy || v) begin
            for (int i = 31; i >= 0; i--) e2[i] = q2.pop_front();
            ev = 1'b1;
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        v0 = 0; v1 = 0; v2 = 0; din0 = '0; din1 = '0; din2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout0 !== 20'h0) begin errs++; $display("FAIL rst_dout0 got=%h exp=0", dout0); end
        checks++; if (dv0 !== 1'b0) begin errs++; $display("FAIL rst_dv0 got=%b exp=0", dv0); end
        checks++; if (r0 !== 1'b0) begin errs++; $display("FAIL rst_ready0 got=%b exp=0", r0); end
        checks++; if (sc0 !== 16'h0) begin errs++; $display("FAIL rst_starve0 got=%h exp=0", sc0); end
        checks++; if (r1 !== 1'b0 || r2 !== 1'b0) begin errs++; $display("FAIL rst_ready12 got=%b%b exp=00", r1, r2); end
        arst = 1'b0;
        #1;
        checks++; if ({r0, r1, r2} !== 3'b111) begin errs++; $display("FAIL rel_ready got=%b exp=111", {r0, r1, r2}); end
        q0.delete(); q2.delete(); e0 = '0; e2 = '0;
    endtask

    task automatic test_steady();
        int nr = 0, gaps = 0;
        logic er, ev;
        for (int c = 0; c < 67; c++) begin
            er = (q0.size() < 20);
            checks++; if (r0 !== er) begin errs++; $display("FAIL steady_ready c=%0d got=%b exp=%b", c, r0, er); end
            if (r0 === 1'b1) nr++;
            din0 = w67(widx); v0 = 1'b1;
            @(posedge clk); #1;
            m0_edge(er, 1'b1, din0, ev);
            if (er) widx++;
            checks++; if (dv0 !== ev || dout0 !== e0) begin errs++; $display("FAIL steady_dout c=%0d got=%b/%h exp=%b/%h", c, dv0, dout0, ev, e0); end
            if (dv0 !== 1'b1) gaps++;
        end
        checks++; if (nr != 20) begin errs++; $display("FAIL steady_accepts got=%0d exp=20", nr); end
        checks++; if (gaps != 0) begin errs++; $display("FAIL steady_gaps got=%0d exp=0", gaps); end
    endtask

    task automatic test_starve();
        int low = 0;
        logic er, ev;
        // From fill 0: accept, drain, drain leaves 7 bits with din_ready high.
        for (int c = 0; c < 3; c++) begin
            er = (q0.size() < 20);
            din0 = w67(widx); v0 = 1'b1;
            @(posedge clk); #1;
            m0_edge(er, 1'b1, din0, ev);
            if (er) widx++;
            checks++; if (dv0 !== ev || dout0 !== e0) begin errs++; $display("FAIL pre_starve c=%0d got=%h exp=%h", c, dout0, e0); end
        end
        for (int c = 0; c < 5; c++) begin
            checks++; if (r0 !== 1'b1) begin errs++; $display("FAIL starve_ready c=%0d got=%b exp=1", c, r0); end
            v0 = 1'b0; din0 = '1;
            @(posedge clk); #1;
            m0_edge(1'b1, 1'b0, din0, ev);
            checks++; if (dv0 !== 1'b0 || dout0 !== e0) begin errs++; $display("FAIL starve_hold c=%0d got=%b/%h exp=0/%h", c, dv0, dout0, e0); end
            if (dv0 === 1'b0) low++;
        end
        checks++; if (low != 5) begin errs++; $display("FAIL starve_len got=%0d exp=5", low); end
`ifdef GEARBOX_STATS_EN
        checks++; if (sc0 !== 16'd5) begin errs++; $display("FAIL starve_cnt got=%0d exp=5", sc0); end
`else
        checks++; if (sc0 !== 16'd0) begin errs++; $display("FAIL starve_cnt got=%0d exp=0", sc0); end
`endif
        for (int c = 0; c < 30; c++) begin
            er = (q0.size() < 20);
            checks++; if (r0 !== er) begin errs++; $display("FAIL resume_ready c=%0d got=%b exp=%b", c, r0, er); end
            din0 = w67(widx); v0 = 1'b1;
            @(posedge clk); #1;
            m0_edge(er, 1'b1, din0, ev);
            if (er) widx++;
            checks++; if (dv0 !== ev || dout0 !== e0) begin errs++; $display("FAIL resume_dout c=%0d got=%h exp=%h", c, dout0, e0); end
        end
    endtask

    task automatic test_reset_mid();
        logic er, ev;
        logic [66:0] wv;
        for (int c = 0; c < 5 && q0.size() == 0; c++) begin
            er = (q0.size() < 20);
            din0 = w67(widx); v0 = 1'b1;
            @(posedge clk); #1;
            m0_edge(er, 1'b1, din0, ev);
            if (er) widx++;
        end
        arst = 1'b1; din0 = w67(99); v0 = 1'b1;
        @(posedge clk); #1;
        checks++; if (dout0 !== 20'h0 || dv0 !== 1'b0 || r0 !== 1'b0) begin errs++; $display("FAIL mid_rst got=%h/%b/%b exp=0/0/0", dout0, dv0, r0); end
        q0.delete(); q2.delete(); e0 = '0; e2 = '0;
        arst = 1'b0;
        #1;
        checks++; if (r0 !== 1'b1) begin errs++; $display("FAIL mid_rel_ready got=%b exp=1", r0); end
        wv = w67(200); din0 = wv;
        @(posedge clk); #1;
        m0_edge(1'b1, 1'b1, wv, ev);
        checks++; if (dout0 !== wv[66:47] || dv0 !== 1'b1) begin errs++; $display("FAIL mid_first got=%h exp=%h", dout0, wv[66:47]); end
        checks++; if (sc0 !== 16'h0) begin errs++; $display("FAIL mid_starve_clr got=%h exp=0", sc0); end
        for (int c = 0; c < 20; c++) begin
            er = (q0.size() < 20);
            checks++; if (r0 !== er) begin errs++; $display("FAIL mid_ready c=%0d got=%b exp=%b", c, r0, er); end
            din0 = w67(300 + c); v0 = 1'b1;
            @(posedge clk); #1;
            m0_edge(er, 1'b1, din0, ev);
            checks++; if (dv0 !== ev || dout0 !== e0) begin errs++; $display("FAIL mid_dout c=%0d got=%h exp=%h", c, dout0, e0); end
        end
        v0 = 1'b0;
    endtask

    task automatic test_equal_width();
        logic [31:0] w, prev;
        prev = dout1;
        for (int c = 0; c < 8; c++) begin
            w = $urandom;
            checks++; if (r1 !== 1'b1) begin errs++; $display("FAIL eq_ready c=%0d got=%b exp=1", c, r1); end
            din1 = w; v1 = (c != 4);
            @(posedge clk); #1;
            if (c != 4) begin
                checks++; if (dout1 !== w || dv1 !== 1'b1) begin errs++; $display("FAIL eq_dout c=%0d got=%h exp=%h", c, dout1, w); end
                prev = w;
            end else begin
                checks++; if (dout1 !== prev || dv1 !== 1'b0) begin errs++; $display("FAIL eq_starve got=%b/%h exp=0/%h", dv1, dout1, prev); end
            end
        end
        v1 = 1'b0;
    endtask

    task automatic test_66_32();
        int nr = 0;
        logic er, ev;
        for (int c = 0; c < 66; c++) begin
            er = (q2.size() < 32);
            checks++; if (r2 !== er) begin errs++; $display("FAIL g66_ready c=%0d got=%b exp=%b", c, r2, er); end
            if (r2 === 1'b1) nr++;
            din2 = {2'($urandom), 32'($urandom), 32'($urandom)}; v2 = 1'b1;
            @(posedge clk); #1;
            m2_edge(er, 1'b1, din2, ev);
            checks++; if (dv2 !== ev || dout2 !== e2) begin errs++; $display("FAIL g66_dout c=%0d got=%b/%h exp=%b/%h", c, dv2, dout2, ev, e2); end
        end
        checks++; if (nr != 32) begin errs++; $display("FAIL g66_accepts got=%0d exp=32", nr); end
        v2 = 1'b0;
    endtask

    task automatic test_stats();
        arst = 1'b1; v0 = 1'b0;
        @(posedge clk); #1;
        arst = 1'b0;
`ifdef GEARBOX_STATS_EN
        repeat (70000) @(posedge clk);
        #1;
        checks++; if (sc0 !== 16'hFFFF) begin errs++; $display("FAIL stats_sat got=%h exp=ffff", sc0); end
        @(posedge clk); #1;
        checks++; if (sc0 !== 16'hFFFF) begin errs++; $display("FAIL stats_hold got=%h exp=ffff", sc0); end
`else
        repeat (10) @(posedge clk);
        #1;
        checks++; if (sc0 !== 16'h0) begin errs++; $display("FAIL stats_off got=%h exp=0", sc0); end
`endif
    endtask

    initial begin
        test_reset();
        test_steady();
        test_starve();
        test_reset_mid();
        test_equal_width();
        test_66_32();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
